fetch_pc_unit: RTL and testbench

- Instruction-fetch stage block that consumes the next-PC value chosen by the fetch next-PC mux.
- Holds the architectural PC register and drives the instruction-memory request/ready handshake.
- Registers the fetched instruction into the IF/ID pipeline register, with stall, flush and bubble handling.
- Supplies PC and PCplus4 back to the next-PC mux and the PC decoder.

---
 rtl/fetch_pc_unit_if.sv | 22 ++
 rtl/fetch_pc_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, imem handshake and IF/ID register with stall/flush/bubble.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misalign_err trap on unaligned targets.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           nextPC,
    input  logic                  stall,
    input  logic                  flush,
    fetch_pc_unit_if.master       imem,
    output logic [31:0]           PC,
    output logic [31:0]           PCplus4,
    output logic [31:0]           if_instr,
    output logic [31:0]           if_pc,
    output logic                  if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] adv_target;
    logic        adv_trap;
    logic        trapped;
    logic        do_adv;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_d;

    // An unaligned target is loaded verbatim so the faulting address stays visible.
    assign adv_trap   = (nextPC[1:0] != 2'b00);
    assign adv_target = adv_trap ? nextPC : (nextPC & 32'hFFFF_FFFC);
    assign trapped    = err_q;
    assign misalign_err = err_q;
`else
    assign adv_trap   = 1'b0;
    assign adv_target = nextPC & 32'hFFFF_FFFC;
    assign trapped    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_valid_d   = if_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        do_adv       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_d        = err_q;
`endif

        if (trapped) begin
            state_d = IDLE;
        end else if (flush) begin
            // Redirect beats stall and ready; any held or returning word is wrong-path.
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            state_d    = FETCH;
            do_adv     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem.imem_ready) begin
                        if (stall) begin
                            hold_instr_d = imem.imem_rdata;
                            hold_pc_d    = pc_q;
                            state_d      = STALLED;
                        end else begin
                            if_instr_d = imem.imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                            do_adv     = 1'b1;
                        end
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                        if_instr_d = NOP_INSTR;
                    end
                end
                STALLED: begin
                    if (!stall) begin
                        if_instr_d = hold_instr_q;
                        if_pc_d    = hold_pc_q;
                        if_valid_d = 1'b1;
                        do_adv     = 1'b1;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (do_adv) begin
            pc_d = adv_target;
            if (adv_trap) begin
                state_d = IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
                err_d   = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
            if_pc_q      <= 32'h0;
            if_valid_q   <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_valid_q   <= if_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            err_q        <= err_d;
`endif
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign PC             = pc_q;
    assign PCplus4        = pc_q + 32'd4;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, streaming, stall, bubbles, flush, wrap, misalign.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ready;
    logic        np_auto;
    logic [31:0] np_val;
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [31:0] next_pc;
    logic [31:0] pc, pc_plus4, if_instr, if_pc;
    logic        if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif
    int checks = 0;
    int errors = 0;

    fetch_pc_unit_if bus ();

    // Memory model: word content is a tag plus the low address bits unless overridden.
    assign bus.imem_ready = ready;
    assign bus.imem_rdata = ovr_en ? ovr_val : {16'hC0DE, bus.imem_addr[15:0]};
    assign next_pc        = np_auto ? pc_plus4 : np_val;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nextPC   (next_pc),
        .stall    (stall),
        .flush    (flush),
        .imem     (bus.master),
        .PC       (pc),
        .PCplus4  (pc_plus4),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .if_valid (if_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%08h req=%0b if_valid=%0b if_pc=%08h if_instr=%08h",
                 $time, pc, bus.imem_req, if_valid, if_pc, if_instr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ready = 1'b1;
        np_auto = 1'b1; np_val = 32'h0; ovr_en = 1'b0; ovr_val = 32'h0;

        // Reset
        step();
        check("rst_pc", pc, 32'h100);
        check("rst_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_err", {31'b0, misalign_err}, 32'h0);
`endif
        rst = 1'b0;

        // IDLE lasts one cycle, then back-to-back fetches
        step();
        check("f0_req", {31'b0, bus.imem_req}, 32'h1);
        check("f0_addr", bus.imem_addr, 32'h100);
        check("f0_pcp4", pc_plus4, 32'h104);
        check("f0_valid", {31'b0, if_valid}, 32'h0);
        step();
        check("f1_addr", bus.imem_addr, 32'h104);
        check("f1_if_pc", if_pc, 32'h100);
        check("f1_instr", if_instr, 32'hC0DE_0100);
        check("f1_valid", {31'b0, if_valid}, 32'h1);

        // Stall for 3 cycles while 0x104 returns DEADBEEF
        ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_req", {31'b0, bus.imem_req}, 32'h0);
            check("st_if_pc", if_pc, 32'h100);
            check("st_instr", if_instr, 32'hC0DE_0100);
            check("st_pc", pc, 32'h104);
        end
        stall = 1'b0; ovr_en = 1'b0;
        step();
        check("rel_instr", if_instr, 32'hDEAD_BEEF);
        check("rel_if_pc", if_pc, 32'h104);
        check("rel_pc", pc, 32'h108);
        step();
        check("nodup_if_pc", if_pc, 32'h108);
        check("nodup_instr", if_instr, 32'hC0DE_0108);

        // Redirect to 0x200, then two wait cycles
        np_auto = 1'b0; np_val = 32'h200; flush = 1'b1;
        step();
        check("fl_pc", pc, 32'h200);
        check("fl_valid", {31'b0, if_valid}, 32'h0);
        flush = 1'b0; np_auto = 1'b1; ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("wait_valid", {31'b0, if_valid}, 32'h0);
            check("wait_pc", pc, 32'h200);
            check("wait_req", {31'b0, bus.imem_req}, 32'h1);
        end
        ready = 1'b1; ovr_en = 1'b1; ovr_val = 32'h1234_5678;
        step();
        check("rdy_instr", if_instr, 32'h1234_5678);
        check("rdy_if_pc", if_pc, 32'h200);
        check("rdy_pc", pc, 32'h204);

        // Flush + stall while STALLED drops the held word
        ovr_val = 32'hCAFE_F00D; stall = 1'b1;
        step();
        check("st2_req", {31'b0, bus.imem_req}, 32'h0);
        np_auto = 1'b0; np_val = 32'h400; flush = 1'b1;
        step();
        check("fs_valid", {31'b0, if_valid}, 32'h0);
        check("fs_instr", if_instr, 32'h0);
        check("fs_addr", bus.imem_addr, 32'h400);
        flush = 1'b0; stall = 1'b0; np_auto = 1'b1; ovr_en = 1'b0;
        step();
        check("fs_if_pc", if_pc, 32'h400);
        check("fs_instr2", if_instr, 32'hC0DE_0400);
        check("fs_pc", pc, 32'h404);

        // PC wrap at top of address space
        np_auto = 1'b0; np_val = 32'hFFFF_FFFC; flush = 1'b1;
        step();
        check("wr_pc", pc, 32'hFFFF_FFFC);
        check("wr_pcp4", pc_plus4, 32'h0);
        flush = 1'b0; np_auto = 1'b1;
        step();
        check("wr_adv", pc, 32'h0);
        check("wr_if_pc", if_pc, 32'hFFFF_FFFC);

        // Unaligned advance target
        np_auto = 1'b0; np_val = 32'h203;
        step();
        check("ma_if_pc", if_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("ma_pc", pc, 32'h203);
        check("ma_err", {31'b0, misalign_err}, 32'h1);
        check("ma_req", {31'b0, bus.imem_req}, 32'h0);
        np_auto = 1'b1;
        step();
        step();
        check("ma_hold_pc", pc, 32'h203);
        check("ma_hold_req", {31'b0, bus.imem_req}, 32'h0);
        check("ma_hold_err", {31'b0, misalign_err}, 32'h1);
`else
        check("ma_pc", pc, 32'h200);
        check("ma_req", {31'b0, bus.imem_req}, 32'h1);
        np_auto = 1'b1;
        step();
        check("ma_next", pc, 32'h204);
`endif

        // Reset in the middle of an active request
        ready = 1'b1; rst = 1'b1;
        step();
        check("rst2_pc", pc, 32'h100);
        check("rst2_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst2_valid", {31'b0, if_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst2_err", {31'b0, misalign_err}, 32'h0);
`endif
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
